// File: rtl/serial_data_compare8.sv
// serial_data_compare8
//   Bit-serial magnitude comparator. Two WIDTH-bit operands arrive one bit
//   pair per valid cycle, MSB first, inside a frame opened by iStart. After
//   WIDTH valid pairs the result {a>b, a==b, a<b} is registered on oData and
//   oDone pulses for one cycle. Gaps (iValid low) between pairs are allowed.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | no frame open; iValid ignored, waits for iStart
//   SHIFT | frame open; consuming bit pairs until WIDTH have been seen
//
// Ports
//   iClk    : clock, rising edge
//   iRst_n  : asynchronous active-low reset
//   iStart  : opens (or restarts) a frame
//   iValid  : iBit_a/iBit_b hold a valid bit pair
//   iBit_a  : operand A bit, MSB first
//   iBit_b  : operand B bit, MSB first
//   oData   : registered result {a>b, a==b, a<b}, 3'b000 until first frame
//   oDone   : one-cycle pulse when oData is updated
//   oBusy   : frame in progress
module serial_data_compare8 #(
  parameter int WIDTH = 8
) (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic       iStart,
  input  logic       iValid,
  input  logic       iBit_a,
  input  logic       iBit_b,
  output logic [2:0] oData,
  output logic       oDone,
  output logic       oBusy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          gt, gt_nxt;
  logic          lt, lt_nxt;
  logic [2:0]    data_nxt;
  logic          done_nxt;
  logic          gt_upd, lt_upd;

  // The first differing bit pair decides; later bits cannot override it.
  assign gt_upd = gt | (~gt & ~lt &  iBit_a & ~iBit_b);
  assign lt_upd = lt | (~gt & ~lt & ~iBit_a &  iBit_b);

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state <= IDLE;
      cnt   <= '0;
      gt    <= 1'b0;
      lt    <= 1'b0;
      oData <= 3'b000;
      oDone <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      gt    <= gt_nxt;
      lt    <= lt_nxt;
      oData <= data_nxt;
      oDone <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    gt_nxt    = gt;
    lt_nxt    = lt;
    data_nxt  = oData;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (iStart) begin
          state_nxt = SHIFT;
          cnt_nxt   = '0;
          gt_nxt    = 1'b0;
          lt_nxt    = 1'b0;
        end
      end
      SHIFT: begin
        if (iStart) begin
          // Restart: the pair presented alongside the strobe is dropped.
          cnt_nxt = '0;
          gt_nxt  = 1'b0;
          lt_nxt  = 1'b0;
        end else if (iValid) begin
          gt_nxt = gt_upd;
          lt_nxt = lt_upd;
          if (cnt == LAST) begin
            data_nxt  = {gt_upd, ~(gt_upd | lt_upd), lt_upd};
            done_nxt  = 1'b1;
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign oBusy = (state == SHIFT);

endmodule

// File: tb/tb_serial_data_compare8.sv
module tb_serial_data_compare8;

  logic       iClk = 1'b0;
  logic       iRst_n = 1'b0;
  logic       iStart = 1'b0;
  logic       iValid = 1'b0;
  logic       iBit_a = 1'b0;
  logic       iBit_b = 1'b0;
  logic [2:0] oData;
  logic       oDone;
  logic       oBusy;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cnt = 0;
  int last_done_cyc = 0;
  int prev_done_cyc = 0;
  int busy_cycles = 0;
  int d0;

  serial_data_compare8 #(.WIDTH(8)) dut (
    .iClk  (iClk),
    .iRst_n(iRst_n),
    .iStart(iStart),
    .iValid(iValid),
    .iBit_a(iBit_a),
    .iBit_b(iBit_b),
    .oData (oData),
    .oDone (oDone),
    .oBusy (oBusy)
  );

  always #5 iClk = ~iClk;

  always @(posedge iClk) cyc <= cyc + 1;

  always @(negedge iClk) begin
    if (oDone === 1'b1) begin
      done_cnt      = done_cnt + 1;
      prev_done_cyc = last_done_cyc;
      last_done_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge iClk);
    #1;
    if (oBusy === 1'b1) busy_cycles++;
  endtask

  // Start strobe then 8 pairs MSB first. Returns in the cycle oDone is high.
  task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input bit gaps);
    busy_cycles = 0;
    iStart = 1'b1;
    iValid = 1'b0;
    step();
    iStart = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (gaps) begin
        iValid = 1'b0;
        repeat ($urandom_range(0, 3)) step();
      end
      iValid = 1'b1;
      iBit_a = a[i];
      iBit_b = b[i];
      step();
    end
    iValid = 1'b0;
  endtask

  initial begin
    #12;
    check("reset_data", {29'd0, oData}, 32'd0);
    check("reset_done", {31'd0, oDone}, 32'd0);
    check("reset_busy", {31'd0, oBusy}, 32'd0);
    iRst_n = 1'b1;
    step();

    // Valid pairs in IDLE are ignored.
    d0 = done_cnt;
    iValid = 1'b1; iBit_a = 1'b1; iBit_b = 1'b0;
    repeat (10) step();
    iValid = 1'b0;
    step();
    check("idle_no_done", done_cnt - d0, 0);
    check("idle_no_busy", {31'd0, oBusy}, 32'd0);

    // Contiguous frame, a<b decided at the LSB.
    d0 = done_cnt;
    send_frame(8'b10101010, 8'b10101011, 1'b0);
    check("f1_done", {31'd0, oDone}, 32'd1);
    check("f1_data", {29'd0, oData}, 32'd1);
    check("f1_busy_low", {31'd0, oBusy}, 32'd0);
    check("f1_busy_cycles", busy_cycles, 8);
    step();
    check("f1_done_single", {31'd0, oDone}, 32'd0);
    check("f1_data_hold", {29'd0, oData}, 32'd1);
    check("f1_pulses", done_cnt - d0, 1);

    send_frame(8'b10101010, 8'b10101001, 1'b0); step();
    check("f2_gt", {29'd0, oData}, 32'd4);
    send_frame(8'b10101010, 8'b10111010, 1'b0); step();
    check("f3_lt", {29'd0, oData}, 32'd1);
    send_frame(8'b10101010, 8'b01011010, 1'b0); step();
    check("f4_msb_frozen", {29'd0, oData}, 32'd4);
    send_frame(8'b10101010, 8'b10101010, 1'b0); step();
    check("f5_eq", {29'd0, oData}, 32'd2);

    // Gapped frame: result same, single pulse right after the 8th pair.
    d0 = done_cnt;
    send_frame(8'b10101010, 8'b10101011, 1'b1);
    check("gap_done", {31'd0, oDone}, 32'd1);
    check("gap_data", {29'd0, oData}, 32'd1);
    step();
    check("gap_pulses", done_cnt - d0, 1);

    // Abort/restart: the pair sent with the restart strobe must be dropped.
    send_frame(8'b10101010, 8'b10101010, 1'b0); step();   // oData = 010
    d0 = done_cnt;
    iStart = 1'b1; step(); iStart = 1'b0;
    for (int i = 0; i < 4; i++) begin
      iValid = 1'b1; iBit_a = 1'b1; iBit_b = 1'b0; step();
    end
    iStart = 1'b1; iValid = 1'b1; iBit_a = 1'b1; iBit_b = 1'b0;
    step();
    iStart = 1'b0;
    check("abort_busy", {31'd0, oBusy}, 32'd1);
    check("abort_data_hold", {29'd0, oData}, 32'd2);
    check("abort_no_done", {31'd0, oDone}, 32'd0);
    for (int i = 7; i >= 0; i--) begin
      iValid = 1'b1; iBit_a = 1'b0; iBit_b = (i == 0); step();
    end
    iValid = 1'b0;
    check("abort_done", {31'd0, oDone}, 32'd1);
    check("abort_data", {29'd0, oData}, 32'd1);
    step();
    check("abort_pulses", done_cnt - d0, 1);

    // Asynchronous reset mid-frame.
    d0 = done_cnt;
    iStart = 1'b1; step(); iStart = 1'b0;
    for (int i = 0; i < 5; i++) begin
      iValid = 1'b1; iBit_a = 1'b1; iBit_b = 1'b1; step();
    end
    #2;
    iRst_n = 1'b0;
    #1;
    check("rst_data", {29'd0, oData}, 32'd0);
    check("rst_busy", {31'd0, oBusy}, 32'd0);
    check("rst_done", {31'd0, oDone}, 32'd0);
    @(posedge iClk); #2;
    iRst_n = 1'b1;
    repeat (6) step();
    iValid = 1'b0;
    step();
    check("rst_no_done", done_cnt - d0, 0);
    check("rst_idle", {31'd0, oBusy}, 32'd0);
    send_frame(8'h5A, 8'h5A, 1'b0); step();
    check("post_rst_eq", {29'd0, oData}, 32'd2);

    // Back-to-back frames, second start in the oDone cycle.
    d0 = done_cnt;
    send_frame(8'h80, 8'h7F, 1'b0);
    check("b2b1_done", {31'd0, oDone}, 32'd1);
    check("b2b1_data", {29'd0, oData}, 32'd4);
    send_frame(8'h7F, 8'h80, 1'b0);
    check("b2b2_done", {31'd0, oDone}, 32'd1);
    check("b2b2_data", {29'd0, oData}, 32'd1);
    step();
    check("b2b_pulses", done_cnt - d0, 2);
    check("b2b_spacing", last_done_cyc - prev_done_cyc, 9);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
